// File: rtl/pool_stream.sv
`default_nettype none
// ============================================================================
//  Module   : pool_stream
//  Purpose  : Streaming POOLxPOOL non-overlapping max/average pooling stage
//             with frame resync and stall tolerance.
//  Option   : POOL_AVG_EN - builds the average-pooling datapath; max-only if undefined.
//  Revision : 1.0 - initial release
// ============================================================================
module pool_stream #(
    parameter int DW    = 9,
    parameter int IMG_W = 28,
    parameter int IMG_H = 28,
    parameter int POOL  = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic signed [DW-1:0] pxl_in,
    input  logic                 pxl_valid,
    input  logic                 sof,
    input  logic                 mode,
    output logic signed [DW-1:0] pool_out,
    output logic                 valid,
    output logic                 last
);

    localparam int LP   = $clog2(POOL);
    localparam int SH   = 2 * LP;
    localparam int NSEG = IMG_W / POOL;
    localparam int CW   = $clog2(IMG_W);
    localparam int RW   = $clog2(IMG_H);
    localparam int IW   = (NSEG > 1) ? $clog2(NSEG) : 1;
`ifdef POOL_AVG_EN
    localparam int AW   = DW + SH;
`else
    localparam int AW   = DW;
`endif

    logic [CW-1:0]          c_q, c_d, col;
    logic [RW-1:0]          r_q, r_d, row;
    logic signed [AW-1:0]   h_q, h_d;
    logic signed [AW-1:0]   pix_x, seg_val, lb_rd, v_comb, lb_wdata;
    logic signed [DW-1:0]   pool_out_q, pool_out_d, win_out;
    logic                   valid_q, valid_d, last_q, last_d;
    logic                   seg_first, seg_end, at_origin, lb_we;
    logic [IW-1:0]          idx;
    logic signed [AW-1:0]   lb_q [NSEG];

    function automatic logic signed [AW-1:0] smax(input logic signed [AW-1:0] a,
                                                  input logic signed [AW-1:0] b);
        return (a > b) ? a : b;
    endfunction

`ifdef POOL_AVG_EN
    logic mode_q, mode_d, mode_cur;
`else
    logic unused_mode;
    assign unused_mode = mode;
`endif

    always_comb begin
        // sof overrides the counters so the pixel is processed as (0,0)
        col       = sof ? '0 : c_q;
        row       = sof ? '0 : r_q;
        at_origin = (col == '0) && (row == '0);
        seg_first = (col[LP-1:0] == '0);
        seg_end   = (col[LP-1:0] == LP'(POOL - 1));
        idx       = IW'(col >> LP);
        lb_rd     = lb_q[idx];
        pix_x     = AW'(pxl_in);
`ifdef POOL_AVG_EN
        mode_cur  = at_origin ? mode : mode_q;
        seg_val   = seg_first ? pix_x : (mode_cur ? h_q + pix_x : smax(h_q, pix_x));
        v_comb    = mode_cur ? lb_rd + seg_val : smax(lb_rd, seg_val);
        win_out   = mode_cur ? DW'(v_comb >>> SH) : DW'(v_comb);
        mode_d    = mode_q;
`else
        seg_val   = seg_first ? pix_x : smax(h_q, pix_x);
        v_comb    = smax(lb_rd, seg_val);
        win_out   = v_comb;
`endif
        c_d        = c_q;
        r_d        = r_q;
        h_d        = h_q;
        lb_we      = 1'b0;
        lb_wdata   = seg_val;
        valid_d    = 1'b0;
        last_d     = 1'b0;
        pool_out_d = pool_out_q;

        if (pxl_valid) begin
            h_d = seg_val;
`ifdef POOL_AVG_EN
            if (at_origin) mode_d = mode;
`endif
            if (col == CW'(IMG_W - 1)) begin
                c_d = '0;
                r_d = (row == RW'(IMG_H - 1)) ? '0 : row + RW'(1);
            end else begin
                c_d = col + CW'(1);
                r_d = row;
            end

            if (seg_end) begin
                if (row[LP-1:0] == '0) begin
                    lb_we = 1'b1;
                end else if (row[LP-1:0] == LP'(POOL - 1)) begin
                    valid_d    = 1'b1;
                    last_d     = (row == RW'(IMG_H - 1)) && (col == CW'(IMG_W - 1));
                    pool_out_d = win_out;
                end else begin
                    lb_we    = 1'b1;
                    lb_wdata = v_comb;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            c_q        <= '0;
            r_q        <= '0;
            h_q        <= '0;
            pool_out_q <= '0;
            valid_q    <= 1'b0;
            last_q     <= 1'b0;
`ifdef POOL_AVG_EN
            mode_q     <= 1'b0;
`endif
        end else begin
            c_q        <= c_d;
            r_q        <= r_d;
            h_q        <= h_d;
            pool_out_q <= pool_out_d;
            valid_q    <= valid_d;
            last_q     <= last_d;
`ifdef POOL_AVG_EN
            mode_q     <= mode_d;
`endif
        end
    end

    // Line buffer carries no reset; row-0 segments always overwrite it
    always_ff @(posedge clk) begin
        if (lb_we) lb_q[idx] <= lb_wdata;
    end

    assign pool_out = pool_out_q;
    assign valid    = valid_q;
    assign last     = last_q;

endmodule
`default_nettype wire

// File: tb/tb_pool_stream.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pool_stream
//  Purpose  : Scoreboard bench for pool_stream on a 4x4 image with 2x2 windows.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pool_stream;

    localparam int DW = 9;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic signed [DW-1:0] pxl_in = '0;
    logic                 pxl_valid = 1'b0;
    logic                 sof = 1'b0;
    logic                 mode = 1'b0;
    logic signed [DW-1:0] pool_out;
    logic                 valid;
    logic                 last;

    pool_stream #(.DW(DW), .IMG_W(4), .IMG_H(4), .POOL(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .pxl_in    (pxl_in),
        .pxl_valid (pxl_valid),
        .sof       (sof),
        .mode      (mode),
        .pool_out  (pool_out),
        .valid     (valid),
        .last      (last)
    );

    always #5 clk = ~clk;

    typedef struct {
        int val;
        bit lst;
        int due;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    logic prev_v = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int expv);
        tests++;
        if (act != expv) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, expv, $time);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a result
    always @(negedge clk) begin
        if (reset) begin
            if (valid) begin
                chk("valid_single_cycle", int'(prev_v), 0);
                if (q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_output: got pool_out=%0d, expected no output", pool_out);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("pool_out", int'(pool_out), e.val);
                    chk("last", int'(last), int'(e.lst));
                    chk("latency_cycle", cyc, e.due);
                end
            end else begin
                chk("last_without_valid", int'(last), 0);
            end
            prev_v <= valid;
        end else begin
            prev_v <= 1'b0;
        end
    end

    task automatic send(input int v, input bit s, input bit m,
                        input bit ex, input int ev, input bit el);
        exp_t e;
        @(negedge clk);
        pxl_in    = DW'(v);
        pxl_valid = 1'b1;
        sof       = s;
        mode      = m;
        if (ex) begin
            e.val = ev;
            e.lst = el;
            e.due = cyc + 1;
            q.push_back(e);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        pxl_valid = 1'b0;
        sof       = 1'b0;
    endtask

    // Drives n_pix pixels of a 4x4 frame; expectations pushed at (odd row, odd col)
    task automatic run_frame(input int px[16], input int ex[4], input bit m,
                             input int flip_at, input bit use_sof,
                             input bit stall, input int n_pix);
        for (int i = 0; i < n_pix; i++) begin
            int  r, c;
            bit  comp;
            r    = i / 4;
            c    = i % 4;
            comp = (r % 2 == 1) && (c % 2 == 1);
            send(px[i], use_sof && (i == 0), (i >= flip_at) ? ~m : m,
                 comp, ex[(r / 2) * 2 + c / 2], i == 15);
            if (stall) idle();
        end
        idle();
    endtask

    int ramp[16];
    int negf[16];
    int e_max[4];
    int e_avg[4];
    int e_negmax[4];
    int e_negavg[4];

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before timeout");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 16; i++) ramp[i] = i + 1;
        negf     = '{-1, -2, -3, -3, -1, -2, -3, -3, 1, 2, -5, -7, 3, 4, -6, -9};
        e_max    = '{6, 8, 14, 16};
        e_negmax = '{-1, -3, 4, -5};
`ifdef POOL_AVG_EN
        e_avg    = '{3, 5, 11, 13};
        e_negavg = '{-2, -3, 2, -7};
`else
        e_avg    = e_max;
        e_negavg = e_negmax;
`endif

        #3 reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_valid", int'(valid), 0);
        chk("reset_last", int'(last), 0);
        chk("reset_pool_out", int'(pool_out), 0);
        reset = 1'b1;

        run_frame(ramp, e_max, 1'b0, 16, 1'b1, 1'b0, 16);
        run_frame(ramp, e_avg, 1'b1, 16, 1'b1, 1'b0, 16);
        run_frame(negf, e_negavg, 1'b1, 16, 1'b1, 1'b0, 16);
        run_frame(negf, e_negmax, 1'b0, 16, 1'b1, 1'b0, 16);
        run_frame(ramp, e_max, 1'b0, 16, 1'b1, 1'b1, 16);

        // Partial frame, then sof lands where (1,1) would complete a window
        run_frame(ramp, e_max, 1'b0, 16, 1'b1, 1'b0, 5);
        run_frame(ramp, e_max, 1'b0, 16, 1'b1, 1'b0, 16);

        // Mode changes after the first pixel must not affect the frame
        run_frame(ramp, e_max, 1'b0, 4, 1'b1, 1'b0, 16);
        run_frame(ramp, e_avg, 1'b1, 4, 1'b1, 1'b0, 16);
        // Frame following without sof keeps counting from (0,0)
        run_frame(ramp, e_max, 1'b0, 16, 1'b0, 1'b0, 16);

        // Reset while a result is on the outputs
        for (int i = 0; i < 7; i++)
            send(i + 1, i == 0, 1'b0, i == 5, 6, 1'b0);
        send(8, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        @(posedge clk);
        #2;
        chk("pre_reset_valid", int'(valid), 1);
        chk("pre_reset_pool_out", int'(pool_out), 8);
        reset = 1'b0;
        #1;
        chk("async_reset_valid", int'(valid), 0);
        chk("async_reset_last", int'(last), 0);
        chk("async_reset_pool_out", int'(pool_out), 0);
        pxl_valid = 1'b0;
        sof       = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        run_frame(ramp, e_max, 1'b0, 16, 1'b0, 1'b0, 16);

        for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
        chk("scoreboard_drained", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
